// File: rtl/audio_stream_bridge.sv
// audio_stream_bridge: per-channel sample FIFOs between an ADC-side and a
// DAC-side valid/ready stream. Samples are transformed (pass, mute,
// attenuate, saturating invert) as they are written, so a mode change only
// affects samples accepted after it.
module audio_stream_bridge #(
  parameter int NCH = 2,
  parameter int DW = 32,
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [4:0]        shift,
  input  logic              flush,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*DW-1:0] in_data,
  output logic [NCH-1:0]    in_ready,
  output logic [NCH-1:0]    out_valid,
  output logic [NCH*DW-1:0] out_data,
  input  logic [NCH-1:0]    out_ready,
  output logic [NCH*LW-1:0] level,
  output logic [NCH-1:0]    overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_MUTE   = 2'b01;
  localparam logic [1:0] MODE_ATTEN  = 2'b10;
  localparam logic [1:0] MODE_INVERT = 2'b11;

  localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MOST_POS = {1'b0, {(DW-1){1'b1}}};

  // Shift amounts at or beyond the sample width collapse to pure sign fill,
  // and negating the most negative value saturates instead of wrapping.
  function automatic logic [DW-1:0] transformSample(input logic [DW-1:0] x,
                                                    input logic [1:0] m,
                                                    input logic [4:0] s);
    logic [DW-1:0] result;
    logic [31:0]   shiftExt;
    shiftExt = {27'd0, s};
    result = x;
    case (m)
      MODE_PASS: result = x;
      MODE_MUTE: result = '0;
      MODE_ATTEN: begin
        if (shiftExt >= 32'(DW)) result = {DW{x[DW-1]}};
        else                     result = $signed(x) >>> s;
      end
      MODE_INVERT: begin
        if (x == MOST_NEG) result = MOST_POS;
        else               result = -x;
      end
      default: result = x;
    endcase
    return result;
  endfunction

  for (genvar c = 0; c < NCH; c++) begin : gChannel
    logic [LW-1:0] level_q, level_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic          overflow_q, overflow_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic          full;
    logic          empty;
    logic          pushEn;
    logic          popEn;
    logic [DW-1:0] storedSample;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

    // Ready is held low during reset and flush so nothing is accepted then.
    assign in_ready[c]  = reset & ~flush & ~full;
    assign out_valid[c] = ~empty;
    assign pushEn       = in_valid[c] & in_ready[c];
    assign popEn        = out_valid[c] & out_ready[c] & ~flush;

    assign storedSample = transformSample(in_data[c*DW +: DW], mode, shift);

    assign out_data[c*DW +: DW] = empty ? '0 : mem_q[rdPtr_q];
    assign level[c*LW +: LW]    = level_q;
    assign overflow[c]          = overflow_q;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
      level_d    = level_q;
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      overflow_d = overflow_q;
      if (flush) begin
        level_d    = '0;
        wrPtr_d    = '0;
        rdPtr_d    = '0;
        overflow_d = 1'b0;
      end else begin
        if (pushEn) wrPtr_d = wrPtr_q + PW'(1);
        if (popEn)  rdPtr_d = rdPtr_q + PW'(1);
        case ({pushEn, popEn})
          2'b10:   level_d = level_q + LW'(1);
          2'b01:   level_d = level_q - LW'(1);
          default: level_d = level_q;
        endcase
        if (in_valid[c] && full) overflow_d = 1'b1;
      end
    end

    // Control state, cleared asynchronously so queued samples are discarded.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        level_q    <= '0;
        wrPtr_q    <= '0;
        rdPtr_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        level_q    <= level_d;
        wrPtr_q    <= wrPtr_d;
        rdPtr_q    <= rdPtr_d;
        overflow_q <= overflow_d;
      end
    end

    // Sample storage needs no reset; empty FIFOs never expose it.
    always_ff @(posedge clock) begin
      if (pushEn) mem_q[wrPtr_q] <= storedSample;
    end
  end

endmodule

// File: tb/tb_audio_stream_bridge.sv
// Directed bench for audio_stream_bridge with hand-computed expected values.
module tb_audio_stream_bridge;

  localparam int NCH = 2;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int LW = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic [1:0]        mode;
  logic [4:0]        shift;
  logic              flush;
  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_ready;
  logic [NCH-1:0]    out_valid;
  logic [NCH*DW-1:0] out_data;
  logic [NCH-1:0]    out_ready;
  logic [NCH*LW-1:0] level;
  logic [NCH-1:0]    overflow;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  audio_stream_bridge #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .mode(mode), .shift(shift), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .level(level), .overflow(overflow)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [4:0] s,
                               input logic fl, input logic [1:0] iv,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [1:0] ordy);
    mode      = m;
    shift     = s;
    flush     = fl;
    in_valid  = iv;
    in_data   = {d1, d0};
    out_ready = ordy;
    #1;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic pushThenCheck(input string tag, input logic [1:0] m,
                               input logic [4:0] s, input logic [31:0] d,
                               input logic [31:0] expected);
    applyStimulus(m, s, 1'b0, 2'b01, d, 32'h0, 2'b01);
    checkOutput({tag, "_nofall"}, {63'd0, out_valid[0]}, 64'd0);
    tick;
    applyStimulus(2'b00, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b01);
    checkOutput(tag, out_data[31:0], expected);
    tick;
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] fillVals [4];
    logic [31:0] drainVals [4];
    logic [1:0]  m;
    logic [31:0] d0, d1;

    reset = 1'b0;
    applyStimulus(2'b00, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("rst_level", level, 64'd0);
    checkOutput("rst_in_ready", in_ready, 64'd0);
    checkOutput("rst_out_valid", out_valid, 64'd0);
    checkOutput("rst_out_data", out_data, 64'd0);
    checkOutput("rst_overflow", overflow, 64'd0);
    reset = 1'b1;
    #1;
    checkOutput("rel_in_ready", in_ready, 64'h3);
    tick;

    // Fill ch0 with four samples while the DAC side is stalled.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b00, 5'd0, 1'b0, 2'b01, 32'(17 * (k + 1)), 32'h0, 2'b00);
      checkOutput($sformatf("fill%0d_level", k), level[LW-1:0], 64'(k));
      checkOutput($sformatf("fill%0d_ready", k), {63'd0, in_ready[0]}, 64'd1);
      checkOutput($sformatf("fill%0d_valid", k), {63'd0, out_valid[0]}, (k > 0) ? 64'd1 : 64'd0);
      tick;
    end
    applyStimulus(2'b00, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("full_level0", level[LW-1:0], 64'd4);
    checkOutput("full_ready0", {63'd0, in_ready[0]}, 64'd0);
    checkOutput("full_level1", level[2*LW-1:LW], 64'd0);
    checkOutput("full_valid", out_valid, 64'h1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b00, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b01);
      checkOutput($sformatf("drain%0d_data", k), out_data[31:0], 64'(17 * (k + 1)));
      tick;
    end
    applyStimulus(2'b00, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("empty_level", level, 64'd0);
    checkOutput("empty_valid", out_valid, 64'd0);
    checkOutput("empty_data", out_data, 64'd0);
    checkOutput("no_overflow", overflow, 64'd0);

    // Push attempt into a full FIFO while popping in the same cycle.
    fillVals  = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    drainVals = '{32'hA1, 32'hA2, 32'hA3, 32'hB0};
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b00, 5'd0, 1'b0, 2'b01, fillVals[k], 32'h0, 2'b00);
      tick;
    end
    applyStimulus(2'b00, 5'd0, 1'b0, 2'b01, 32'hB0, 32'h0, 2'b01);
    checkOutput("ovf_ready0", {63'd0, in_ready[0]}, 64'd0);
    checkOutput("ovf_head", out_data[31:0], 64'hA0);
    tick;
    applyStimulus(2'b00, 5'd0, 1'b0, 2'b01, 32'hB0, 32'h0, 2'b00);
    checkOutput("ovf_level", level[LW-1:0], 64'd3);
    checkOutput("ovf_flag", overflow, 64'h1);
    checkOutput("ovf_head2", out_data[31:0], 64'hA1);
    checkOutput("ovf_ready_again", {63'd0, in_ready[0]}, 64'd1);
    tick;
    applyStimulus(2'b00, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b01);
    checkOutput("ovf_refill_level", level[LW-1:0], 64'd4);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b00, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b01);
      checkOutput($sformatf("ovf_drain%0d", k), out_data[31:0], 64'(drainVals[k]));
      tick;
    end
    checkOutput("ovf_sticky", overflow, 64'h1);
    applyStimulus(2'b00, 5'd0, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("flush_ready", in_ready, 64'd0);
    tick;
    applyStimulus(2'b00, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("flush_ovf_clear", overflow, 64'd0);

    // Transform vectors; each pops under mode 00 to show queued data is fixed.
    pushThenCheck("atten4", 2'b10, 5'd4, 32'hFFFF_FF00, 32'hFFFF_FFF0);
    pushThenCheck("atten1", 2'b10, 5'd1, 32'h0000_0006, 32'h0000_0003);
    pushThenCheck("atten31pos", 2'b10, 5'd31, 32'h7FFF_FFFF, 32'h0000_0000);
    pushThenCheck("atten31neg", 2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);
    pushThenCheck("invert_min", 2'b11, 5'd0, 32'h8000_0000, 32'h7FFF_FFFF);
    pushThenCheck("invert5", 2'b11, 5'd0, 32'h0000_0005, 32'hFFFF_FFFB);
    pushThenCheck("mute", 2'b01, 5'd0, 32'h0000_1234, 32'h0000_0000);
    pushThenCheck("pass", 2'b00, 5'd0, 32'hCAFE_BABE, 32'hCAFE_BABE);

    // Continuous streaming on both channels with a mode switch mid-stream.
    for (int k = 0; k < 2; k++) begin
      d0 = 32'h100 + 32'(k);
      d1 = 32'h200 + 32'(k);
      applyStimulus(2'b00, 5'd0, 1'b0, 2'b11, d0, d1, 2'b00);
      q0.push_back(d0);
      q1.push_back(d1);
      tick;
    end
    for (int i = 0; i < 8; i++) begin
      m  = (i < 4) ? 2'b00 : 2'b01;
      d0 = 32'h102 + 32'(i);
      d1 = 32'h202 + 32'(i);
      applyStimulus(m, 5'd0, 1'b0, 2'b11, d0, d1, 2'b11);
      checkOutput($sformatf("stream%0d_level", i), level, {58'd0, 3'd2, 3'd2});
      checkOutput($sformatf("stream%0d_ch0", i), out_data[31:0], 64'(q0[0]));
      checkOutput($sformatf("stream%0d_ch1", i), out_data[63:32], 64'(q1[0]));
      void'(q0.pop_front());
      void'(q1.pop_front());
      q0.push_back((m == 2'b01) ? 32'h0 : d0);
      q1.push_back((m == 2'b01) ? 32'h0 : d1);
      tick;
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(2'b00, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
      checkOutput($sformatf("tail%0d_ch0", k), out_data[31:0], 64'(q0[0]));
      checkOutput($sformatf("tail%0d_ch1", k), out_data[63:32], 64'(q1[0]));
      void'(q0.pop_front());
      void'(q1.pop_front());
      tick;
    end

    // Overflow on ch1 down to level 3, then flush with traffic present.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b00, 5'd0, 1'b0, 2'b10, 32'h0, 32'h300 + 32'(k), 2'b00);
      tick;
    end
    applyStimulus(2'b00, 5'd0, 1'b0, 2'b10, 32'h0, 32'h399, 2'b10);
    tick;
    applyStimulus(2'b00, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("ch1_level3", level[2*LW-1:LW], 64'd3);
    checkOutput("ch1_overflow", overflow, 64'h2);
    applyStimulus(2'b00, 5'd0, 1'b1, 2'b11, 32'h5, 32'h6, 2'b11);
    checkOutput("flush2_ready", in_ready, 64'd0);
    tick;
    applyStimulus(2'b00, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("flush2_level", level, 64'd0);
    checkOutput("flush2_overflow", overflow, 64'd0);
    checkOutput("flush2_valid", out_valid, 64'd0);

    // Reset dropped mid-stream clears everything immediately.
    applyStimulus(2'b00, 5'd0, 1'b0, 2'b11, 32'hAA, 32'hBB, 2'b00);
    tick;
    tick;
    applyStimulus(2'b00, 5'd0, 1'b0, 2'b11, 32'hCC, 32'hDD, 2'b11);
    checkOutput("pre_rst_level", level, {58'd0, 3'd2, 3'd2});
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_level", level, 64'd0);
    checkOutput("mid_rst_valid", out_valid, 64'd0);
    checkOutput("mid_rst_data", out_data, 64'd0);
    checkOutput("mid_rst_ready", in_ready, 64'd0);
    checkOutput("mid_rst_overflow", overflow, 64'd0);
    tick;
    applyStimulus(2'b00, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
    reset = 1'b1;
    #1;
    checkOutput("rel2_ready", in_ready, 64'h3);
    tick;
    checkOutput("rel2_valid", out_valid, 64'd0);
    checkOutput("rel2_level", level, 64'd0);
    pushThenCheck("post_reset", 2'b00, 5'd0, 32'h0000_0077, 32'h0000_0077);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/audio_stream_bridge.md
AUDIO_STREAM_BRIDGE -- requirements
Module: audio_stream_bridge

Interface
REQ-001 Parameter NCH, default 2, number of independent audio channels (>=1).
REQ-002 Parameter DW, default 32, sample width in bits (two's complement).
REQ-003 Parameter DEPTH, default 4, per-channel FIFO depth (power of 2, >=2); LW = clog2(DEPTH+1).
REQ-004 Port: clock  in  1  sole clock; all state updates on rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-low reset.
REQ-006 Port: mode  in  2  00 pass, 01 mute, 10 attenuate, 11 invert.
REQ-007 Port: shift  in  5  right-shift amount used by attenuate mode.
REQ-008 Port: flush  in  1  synchronous clear of all FIFOs.
REQ-009 Port: in_valid  in  NCH  per-channel ADC-side sample valid.
REQ-010 Port: in_data  in  NCH*DW  per-channel ADC samples; channel c at bits [c*DW +: DW].
REQ-011 Port: in_ready  out  NCH  per-channel accept indication.
REQ-012 Port: out_valid  out  NCH  per-channel DAC-side sample valid.
REQ-013 Port: out_data  out  NCH*DW  per-channel processed samples, same packing as in_data.
REQ-014 Port: out_ready  in  NCH  per-channel DAC accept.
REQ-015 Port: level  out  NCH*LW  per-channel FIFO occupancy, channel c at [c*LW +: LW].
REQ-016 Port: overflow  out  NCH  per-channel sticky flag, in_valid seen while full.

Function
REQ-017 Each channel SHALL own one DEPTH-entry FIFO; channels SHALL be fully independent.
REQ-018 in_ready[c] SHALL be 1 exactly when level[c] < DEPTH and flush = 0; it SHALL NOT depend on out_ready.
REQ-019 Push on channel c SHALL occur when in_valid[c] & in_ready[c]; pop when out_valid[c] & out_ready[c].
REQ-020 out_valid[c] SHALL be 1 exactly when level[c] > 0; out_data[c] SHALL be the oldest entry, undefined-free (zero) when empty.
REQ-021 Latency: a sample pushed into an empty FIFO in cycle N SHALL appear on out_data with out_valid=1 in cycle N+1; no fall-through in cycle N.
REQ-022 Simultaneous push and pop SHALL leave level unchanged and preserve order; push-only +1, pop-only -1.
REQ-023 Samples SHALL be transformed at push time using mode/shift sampled in the push cycle; queued samples are not altered by later mode changes.
REQ-024 Mode 00: stored = in_data.
REQ-025 Mode 01: stored = 0; handshakes still occur so sample rate is kept.
REQ-026 Mode 10: stored = in_data arithmetic-shifted right by shift; shift >= DW yields all sign bits (0 or -1).
REQ-027 Mode 11: stored = -in_data, saturating: -2^(DW-1) becomes 2^(DW-1)-1.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH; full/empty SHALL derive from level, never pointer equality alone.
REQ-029 overflow[c] SHALL set on any cycle with in_valid[c]=1 and level[c]=DEPTH and hold until reset or flush; no data dropped or overwritten.
REQ-030 flush=1 SHALL, at the next edge, set all levels and pointers to 0 and clear overflow; push and pop in that cycle are ignored (in_ready=0; pop discarded).

Reset
REQ-031 While reset=0: level=0, pointers=0, out_valid=0, out_data=0, in_ready=0, overflow=0, asynchronously.
REQ-032 First rising edge after reset release SHALL see in_ready=1 on all channels; FIFO storage contents need not be cleared.
REQ-033 Reset asserted mid-transfer SHALL discard all queued samples; no sample emitted after release without a new push.

Verification
REQ-034 Defaults, mode=00, out_ready=0: push 0x11,0x22,0x33,0x44 on ch0 -> level[0]=4, in_ready[0]=0, ch1 level 0; then out_ready=1 -> 0x11..0x44 in order, one per cycle.
REQ-035 Full FIFO, in_valid[0]=1, out_ready=1 same cycle -> no push, one pop, level 3, overflow[0]=1; next cycle push accepted.
REQ-036 mode=10, shift=4: push 0xFFFF_FF00 -> 0xFFFF_FFF0; shift=31 on 0x7FFF_FFFF -> 0; shift=31 on 0x8000_0000 -> 0xFFFF_FFFF.
REQ-037 mode=11: push 0x8000_0000 -> 0x7FFF_FFFF; push 0x0000_0005 -> 0xFFFF_FFFB; mode=01 push 0x1234 -> 0.
REQ-038 Continuous push/pop both channels, mode switched 00->01 mid-stream -> samples queued before switch emerge unmodified, later ones zero, level constant.
REQ-039 level[1]=3, overflow[1]=1, assert flush one cycle with in_valid=1 -> level 0, overflow 0, out_valid 0; reset low mid-stream -> all outputs zero immediately.
